// File: rtl/sb_tx_arbiter_if.sv
// Sideband message type plus the bundle of requester-side and serializer-side
// signals shared by the TX arbiter and its environment.
package sb_pkg;

  typedef struct packed {
    logic [4:0]  opcode;
    logic [7:0]  msg_code;
    logic [15:0] msg_info;
    logic [7:0]  msg_subcode;
  } SB_msg_t;

  function automatic SB_msg_t reset_SB_msg();
    return '0;
  endfunction

endpackage

interface sb_tx_arbiter_if #(
  parameter int N_REQ = 4
) ();
  import sb_pkg::*;

  logic    [N_REQ-1:0]       req_valid_i;
  SB_msg_t [N_REQ-1:0]       req_msg_i;
  logic    [N_REQ-1:0][63:0] req_data_i;
  logic    [N_REQ-1:0]       req_ack_o;
  logic    [N_REQ-1:0]       retry_clr_i;
  logic    [N_REQ-1:0]       retry_timeout_flag_o;
  SB_msg_t                   SB_TX_msg_o;
  logic    [63:0]            SB_TX_dataBus_o;
  logic                      SB_TX_msg_valid_o;
  logic                      SB_TX_msg_sendNextFlag_i;

  // master: the arbiter; slave: requesters plus serializer
  modport master (
    input  req_valid_i, req_msg_i, req_data_i, retry_clr_i, SB_TX_msg_sendNextFlag_i,
    output req_ack_o, retry_timeout_flag_o, SB_TX_msg_o, SB_TX_dataBus_o, SB_TX_msg_valid_o
  );

  modport slave (
    output req_valid_i, req_msg_i, req_data_i, retry_clr_i, SB_TX_msg_sendNextFlag_i,
    input  req_ack_o, retry_timeout_flag_o, SB_TX_msg_o, SB_TX_dataBus_o, SB_TX_msg_valid_o
  );

endinterface

// File: rtl/sb_tx_arbiter.sv
// Round-robin arbiter sharing the sideband TX serializer between LTSM state
// modules, with one periodic retry-timeout counter per requester.
module sb_tx_arbiter
  import sb_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 800000,
  parameter int TMO_W          = 20,
  parameter int MIN_GAP        = 2
) (
  input  logic                     clk_100MHz,
  input  logic                     reset,
  input  logic                     enable_i,
  sb_tx_arbiter_if.master          bus,
  output logic [$clog2(N_REQ)-1:0] grant_id_o,
  output logic                     busy_o
);

  localparam int GW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, GAP, WAIT_READY} state_e;

  state_e                       state_q, state_d;
  logic [2:0]                   gap_q, gap_d;
  logic [GW-1:0]                rr_q, rr_d;
  logic [GW-1:0]                grant_q, grant_d;
  SB_msg_t                      msg_q, msg_d;
  logic [63:0]                  data_q, data_d;
  logic                         valid_q, valid_d;
  logic [N_REQ-1:0]             ack_q, ack_d;
  logic                         busy_q, busy_d;
  logic [N_REQ-1:0][TMO_W-1:0]  cnt_q, cnt_d;
  logic [N_REQ-1:0]             armed_q, armed_d;
  logic [N_REQ-1:0]             flag_q, flag_d;

  logic          win_found;
  logic [GW-1:0] win_idx;
  logic [GW-1:0] cand;
  logic          issue;

  // First valid requester at or after the rr pointer, wrapping.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = GW'((int'(rr_q) + k) % N_REQ);
      if (!win_found && bus.req_valid_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign issue = (state_q == IDLE) && enable_i && bus.SB_TX_msg_sendNextFlag_i && win_found;

  // Next-state logic; GAP masks the stale sendNextFlag seen right after an issue.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d = GAP;
          gap_d   = 3'(MIN_GAP);
        end
      end
      GAP: begin
        gap_d = gap_q - 3'd1;
        if (gap_d == 3'd0) state_d = WAIT_READY;
      end
      WAIT_READY: begin
        if (bus.SB_TX_msg_sendNextFlag_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Issue datapath.
  always_comb begin
    msg_d   = msg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ack_d   = '0;
    grant_d = grant_q;
    rr_d    = rr_q;
    if (issue) begin
      msg_d          = bus.req_msg_i[win_idx];
      data_d         = bus.req_data_i[win_idx];
      valid_d        = 1'b1;
      ack_d[win_idx] = 1'b1;
      grant_d        = win_idx;
      rr_d           = (win_idx == GW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
    busy_d = (state_d != IDLE);
  end

  // Retry timers: ack re-arms and wins over clear; expiry restarts the period.
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    flag_d  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ack_d[i]) begin
        cnt_d[i]   = '0;
        armed_d[i] = 1'b1;
      end else if (bus.retry_clr_i[i] || !enable_i) begin
        cnt_d[i]   = '0;
        armed_d[i] = 1'b0;
      end else if (armed_q[i] && cnt_q[i] == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        cnt_d[i]  = '0;
        flag_d[i] = 1'b1;
      end else if (armed_q[i]) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q <= IDLE;
      gap_q   <= '0;
      rr_q    <= '0;
      grant_q <= '0;
      msg_q   <= reset_SB_msg();
      data_q  <= '0;
      valid_q <= 1'b0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      armed_q <= '0;
      flag_q  <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      msg_q   <= msg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      flag_q  <= flag_d;
    end
  end

  assign bus.SB_TX_msg_o          = msg_q;
  assign bus.SB_TX_dataBus_o      = data_q;
  assign bus.SB_TX_msg_valid_o    = valid_q;
  assign bus.req_ack_o            = ack_q;
  assign bus.retry_timeout_flag_o = flag_q;
  assign grant_id_o               = grant_q;
  assign busy_o                   = busy_q;

endmodule

// File: tb/tb_sb_tx_arbiter.sv
// Directed bench for sb_tx_arbiter: N_REQ=4, TIMEOUT_CYCLES=20, MIN_GAP=2.
module tb_sb_tx_arbiter;
  import sb_pkg::*;

  localparam int N_REQ = 4;

  logic       clk_100MHz;
  logic       reset;
  logic       enable_i;
  logic [1:0] grant_id_o;
  logic       busy_o;
  int         n_checks;
  int         n_errors;
  SB_msg_t    msgs [N_REQ];
  logic [63:0] datas [N_REQ];

  sb_tx_arbiter_if #(.N_REQ(N_REQ)) bus ();

  sb_tx_arbiter #(
    .N_REQ(N_REQ), .TIMEOUT_CYCLES(20), .TMO_W(20), .MIN_GAP(2)
  ) dut (
    .clk_100MHz(clk_100MHz),
    .reset(reset),
    .enable_i(enable_i),
    .bus(bus),
    .grant_id_o(grant_id_o),
    .busy_o(busy_o)
  );

  initial begin
    clk_100MHz = 1'b0;
    forever #5 clk_100MHz = ~clk_100MHz;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Outputs are sampled and inputs changed on the falling edge.
  task automatic step();
    @(negedge clk_100MHz);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    enable_i = 1'b1;
    bus.req_valid_i = '0;
    bus.retry_clr_i = '0;
    bus.SB_TX_msg_sendNextFlag_i = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({bus.SB_TX_msg_valid_o, bus.req_ack_o, grant_id_o, busy_o, bus.retry_timeout_flag_o} !== '0) begin
      n_errors++;
      $display("FAIL reset_ctrl: valid=%b ack=%b grant=%0d busy=%b flag=%b, want all 0",
               bus.SB_TX_msg_valid_o, bus.req_ack_o, grant_id_o, busy_o, bus.retry_timeout_flag_o);
    end
    n_checks++;
    if (bus.SB_TX_msg_o !== reset_SB_msg() || bus.SB_TX_dataBus_o !== 64'd0) begin
      n_errors++;
      $display("FAIL reset_data: msg=%h data=%h, want 0", bus.SB_TX_msg_o, bus.SB_TX_dataBus_o);
    end
  endtask

  task automatic test_single();
    logic [3:0] exp_flag;
    do_reset();
    bus.req_valid_i = 4'b0001;
    step();  // edge 0
    n_checks++;
    if (bus.SB_TX_msg_valid_o !== 1'b1 || bus.req_ack_o !== 4'b0001 || grant_id_o !== 2'd0) begin
      n_errors++;
      $display("FAIL single_issue: valid=%b ack=%b grant=%0d, want 1 0001 0",
               bus.SB_TX_msg_valid_o, bus.req_ack_o, grant_id_o);
    end
    n_checks++;
    if (bus.SB_TX_msg_o !== msgs[0] || bus.SB_TX_dataBus_o !== datas[0]) begin
      n_errors++;
      $display("FAIL single_payload: msg=%h data=%h, want %h %h",
               bus.SB_TX_msg_o, bus.SB_TX_dataBus_o, msgs[0], datas[0]);
    end
    bus.req_valid_i = '0;
    for (int k = 1; k <= 41; k++) begin
      step();
      if (k == 1) begin
        n_checks++;
        if (bus.SB_TX_msg_valid_o !== 1'b0 || bus.req_ack_o !== 4'b0000 || busy_o !== 1'b1) begin
          n_errors++;
          $display("FAIL single_pulse: valid=%b ack=%b busy=%b, want 0 0000 1",
                   bus.SB_TX_msg_valid_o, bus.req_ack_o, busy_o);
        end
      end
      if (k == 5) begin
        n_checks++;
        if (bus.SB_TX_msg_o !== msgs[0]) begin
          n_errors++;
          $display("FAIL single_hold: msg=%h, want %h", bus.SB_TX_msg_o, msgs[0]);
        end
      end
      exp_flag = (k == 20 || k == 40) ? 4'b0001 : 4'b0000;
      n_checks++;
      if (bus.retry_timeout_flag_o !== exp_flag) begin
        n_errors++;
        $display("FAIL single_timeout edge %0d: flag=%b, want %b", k, bus.retry_timeout_flag_o, exp_flag);
      end
    end
  endtask

  task automatic test_round_robin();
    int         exp_g [8];
    int         eg;
    logic [3:0] ea;
    exp_g = '{0, 1, 2, 3, 0, 1, 3, 1};
    do_reset();
    bus.req_valid_i = 4'b1111;
    for (int e = 0; e <= 28; e++) begin
      step();
      n_checks++;
      if (e % 4 == 0) begin
        eg = exp_g[e / 4];
        ea = 4'(1 << eg);
        if (bus.SB_TX_msg_valid_o !== 1'b1 || grant_id_o !== 2'(eg) || bus.req_ack_o !== ea ||
            bus.SB_TX_msg_o !== msgs[eg]) begin
          n_errors++;
          $display("FAIL rr_grant edge %0d: valid=%b grant=%0d ack=%b msg=%h, want 1 %0d %b %h",
                   e, bus.SB_TX_msg_valid_o, grant_id_o, bus.req_ack_o, bus.SB_TX_msg_o, eg, ea, msgs[eg]);
        end
      end else if (bus.SB_TX_msg_valid_o !== 1'b0 || bus.req_ack_o !== 4'b0000) begin
        n_errors++;
        $display("FAIL rr_idle edge %0d: valid=%b ack=%b, want 0 0000",
                 e, bus.SB_TX_msg_valid_o, bus.req_ack_o);
      end
      if (e == 20) bus.req_valid_i = 4'b1010;
    end
  endtask

  task automatic test_pacing();
    do_reset();
    bus.req_valid_i = 4'b0100;
    step();  // edge 0: issue to 2
    n_checks++;
    if (bus.SB_TX_msg_valid_o !== 1'b1 || grant_id_o !== 2'd2) begin
      n_errors++;
      $display("FAIL pace_first: valid=%b grant=%0d, want 1 2", bus.SB_TX_msg_valid_o, grant_id_o);
    end
    bus.SB_TX_msg_sendNextFlag_i = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      n_checks++;
      if (bus.SB_TX_msg_valid_o !== 1'b0 || busy_o !== 1'b1) begin
        n_errors++;
        $display("FAIL pace_stall edge %0d: valid=%b busy=%b, want 0 1", k, bus.SB_TX_msg_valid_o, busy_o);
      end
    end
    bus.SB_TX_msg_sendNextFlag_i = 1'b1;
    step();  // edge 11: WAIT_READY -> IDLE
    n_checks++;
    if (bus.SB_TX_msg_valid_o !== 1'b0) begin
      n_errors++;
      $display("FAIL pace_release: valid=%b, want 0", bus.SB_TX_msg_valid_o);
    end
    step();  // edge 12: reissue
    n_checks++;
    if (bus.SB_TX_msg_valid_o !== 1'b1 || grant_id_o !== 2'd2 || bus.req_ack_o !== 4'b0100 || busy_o !== 1'b1) begin
      n_errors++;
      $display("FAIL pace_reissue: valid=%b grant=%0d ack=%b busy=%b, want 1 2 0100 1",
               bus.SB_TX_msg_valid_o, grant_id_o, bus.req_ack_o, busy_o);
    end
  endtask

  task automatic test_clear_vs_timeout();
    int bad;
    do_reset();
    bus.req_valid_i = 4'b0001;
    step();  // edge 0
    bus.req_valid_i = '0;
    for (int k = 1; k <= 19; k++) step();
    bus.retry_clr_i = 4'b0001;  // sampled at edge 20, counter == 19
    step();
    bus.retry_clr_i = '0;
    n_checks++;
    if (bus.retry_timeout_flag_o !== 4'b0000) begin
      n_errors++;
      $display("FAIL clr_at_expiry: flag=%b, want 0000", bus.retry_timeout_flag_o);
    end
    bad = 0;
    for (int k = 21; k <= 45; k++) begin
      step();
      if (bus.retry_timeout_flag_o !== 4'b0000) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL clr_disarm: %0d cycles flagged, want 0", bad);
    end
    bus.req_valid_i = 4'b0001;
    bus.retry_clr_i = 4'b0001;
    step();  // ack and clear on the same edge
    bus.req_valid_i = '0;
    bus.retry_clr_i = '0;
    n_checks++;
    if (bus.req_ack_o !== 4'b0001) begin
      n_errors++;
      $display("FAIL ackclr_ack: ack=%b, want 0001", bus.req_ack_o);
    end
    bad = 0;
    for (int k = 1; k <= 19; k++) begin
      step();
      if (bus.retry_timeout_flag_o !== 4'b0000) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL ackclr_early: %0d early flag cycles, want 0", bad);
    end
    step();
    n_checks++;
    if (bus.retry_timeout_flag_o !== 4'b0001) begin
      n_errors++;
      $display("FAIL ackclr_rearm: flag=%b at +20, want 0001", bus.retry_timeout_flag_o);
    end
  endtask

  task automatic test_enable();
    int bad;
    do_reset();
    bus.req_valid_i = 4'b0001;
    step();  // edge 0: issue to 0
    bus.req_valid_i = '0;
    step();
    step();  // edge 2: now WAIT_READY
    enable_i = 1'b0;
    bus.SB_TX_msg_sendNextFlag_i = 1'b0;
    bus.req_valid_i = 4'b0010;
    step();
    step();  // edges 3,4
    n_checks++;
    if (busy_o !== 1'b1 || bus.SB_TX_msg_valid_o !== 1'b0) begin
      n_errors++;
      $display("FAIL en_inflight: busy=%b valid=%b, want 1 0", busy_o, bus.SB_TX_msg_valid_o);
    end
    bus.SB_TX_msg_sendNextFlag_i = 1'b1;
    bad = 0;
    for (int k = 5; k <= 30; k++) begin
      step();
      if (bus.SB_TX_msg_valid_o !== 1'b0 || bus.retry_timeout_flag_o !== 4'b0000) bad++;
    end
    n_checks++;
    if (bad != 0 || busy_o !== 1'b0) begin
      n_errors++;
      $display("FAIL en_blocked: %0d cycles with valid/flag, busy=%b, want 0 0", bad, busy_o);
    end
    enable_i = 1'b1;
    step();
    n_checks++;
    if (bus.SB_TX_msg_valid_o !== 1'b1 || grant_id_o !== 2'd1 || bus.req_ack_o !== 4'b0010) begin
      n_errors++;
      $display("FAIL en_resume: valid=%b grant=%0d ack=%b, want 1 1 0010",
               bus.SB_TX_msg_valid_o, grant_id_o, bus.req_ack_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req_valid_i = 4'b0001;
    step();  // edge 0: issue to 0
    reset = 1'b1;
    bus.req_valid_i = 4'b1111;
    step();  // edge 1: reset
    n_checks++;
    if (bus.SB_TX_msg_valid_o !== 1'b0 || bus.req_ack_o !== 4'b0000 || busy_o !== 1'b0 ||
        grant_id_o !== 2'd0 || bus.SB_TX_msg_o !== reset_SB_msg()) begin
      n_errors++;
      $display("FAIL midreset: valid=%b ack=%b busy=%b grant=%0d msg=%h, want 0 0000 0 0 %h",
               bus.SB_TX_msg_valid_o, bus.req_ack_o, busy_o, grant_id_o, bus.SB_TX_msg_o, reset_SB_msg());
    end
    reset = 1'b0;
    step();  // edge 2: rr pointer back at 0
    n_checks++;
    if (bus.SB_TX_msg_valid_o !== 1'b1 || grant_id_o !== 2'd0 || bus.req_ack_o !== 4'b0001) begin
      n_errors++;
      $display("FAIL midreset_rr: valid=%b grant=%0d ack=%b, want 1 0 0001",
               bus.SB_TX_msg_valid_o, grant_id_o, bus.req_ack_o);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < N_REQ; i++) begin
      msgs[i].opcode      = 5'(i + 1);
      msgs[i].msg_code    = 8'(8'h40 + i);
      msgs[i].msg_info    = 16'(16'hBEE0 + i);
      msgs[i].msg_subcode = 8'(8'hC0 + i);
      datas[i]            = 64'hDA7A_0000_0000_0000 | 64'(i * 32'h0101_0101 + 1);
      bus.req_msg_i[i]    = msgs[i];
      bus.req_data_i[i]   = datas[i];
    end
    test_reset();
    test_single();
    test_round_robin();
    test_pacing();
    test_clear_vs_timeout();
    test_enable();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
